// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin sharing of one fifo write port among N_REQ producers, burst-locked to MAX_BURST words.
// Latency: one cycle from first req_valid in IDLE to the first possible write; back-to-back grants have no bubble.
// Backpressure: fifo full stalls the current owner (grant held, beat count frozen, no timeout); non-owners are never ready.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   req_valid/req_data  - per-producer word offer, producer i data on [i*D_WIDTH +: D_WIDTH]
//   req_ready           - per-producer accept, only the owner can see it high
//   full                - fifo full flag
//   wr/w_data           - fifo write strobe and data
//   grant/busy          - registered one-hot owner and "in GRANT" flag
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int D_WIDTH   = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       full,
    output logic                       wr,
    output logic [D_WIDTH-1:0]         w_data,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy
);

    localparam int IW  = $clog2(N_REQ);
    localparam int IW1 = IW + 1;
    localparam int BW  = $clog2(MAX_BURST) + 1;

    localparam logic [BW-1:0]  LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0]  LAST_IDX  = IW'(N_REQ - 1);
    localparam logic [IW1-1:0] N_WIDE    = IW1'(N_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     owner, owner_nxt;
    logic [IW-1:0]     last, last_nxt;
    logic [BW-1:0]     beat_cnt, beat_cnt_nxt;
    logic [N_REQ-1:0]  grant_q, grant_nxt;

    logic [IW-1:0]     arb_start;
    logic [IW-1:0]     arb_win;
    logic              arb_found;
    logic [IW1-1:0]    idx;

    logic              in_grant;
    logic              own_valid;
    logic [D_WIDTH-1:0] own_data;
    logic              accept;
    logic              release_now;

    // Arbitration always starts one past the most recent owner: the live
    // owner while in GRANT (release re-arbitrates the same cycle), or the
    // remembered last owner while in IDLE. Wrapping reaches the old owner
    // last, so a sole requester that hit its burst limit is regranted.
    always_comb begin
        arb_start = (state == GRANT) ? owner : last;
        arb_start = (arb_start == LAST_IDX) ? '0 : arb_start + 1'b1;
        arb_found = 1'b0;
        arb_win   = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, arb_start} + IW1'(k);
            if (idx >= N_WIDE) begin
                idx = idx - N_WIDE;
            end
            if (!arb_found && req_valid[idx[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = idx[IW-1:0];
            end
        end
    end

    assign own_valid = req_valid[owner];
    assign own_data  = req_data[int'(owner)*D_WIDTH +: D_WIDTH];

    // Reset cycle is masked so a burst interrupted by rst never transfers
    // a word on the edge that aborts it.
    assign in_grant = (state == GRANT) && !rst;
    assign accept   = in_grant && own_valid && !full;

    always_comb begin
        req_ready = '0;
        if (in_grant && !full) begin
            req_ready[owner] = 1'b1;
        end
    end

    assign wr     = accept;
    assign w_data = in_grant ? own_data : '0;

    // Owner yields when it goes quiet or its final permitted beat is taken.
    // A full-stall (valid, full) is neither, so grant and beat_cnt hold.
    assign release_now = (state == GRANT) &&
                         (!own_valid || (accept && (beat_cnt == LAST_BEAT)));

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_nxt     = last;
        beat_cnt_nxt = beat_cnt;
        grant_nxt    = '0;

        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt    = GRANT;
                    owner_nxt    = arb_win;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_nxt     = owner;
                    beat_cnt_nxt = '0;
                    if (arb_found) begin
                        owner_nxt = arb_win;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == GRANT) begin
            grant_nxt[owner_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= LAST_IDX;
            beat_cnt <= '0;
            grant_q  <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_cnt_nxt;
            grant_q  <= grant_nxt;
        end
    end

    assign grant = grant_q;
    assign busy  = (state == GRANT);

endmodule
